gate_capture: RTL and testbench
===============================

# gate_capture

Gate-signal capture block for the open-loop SMPS controller. It samples the two complementary gate drives produced by the `dpwm` block (`c1`, `c2`) and measures, in `clk` cycles, the c1 on-time, the c1→c2 dead-time, the c2 on-time, the c2→c1 dead-time and the total period. It also flags shoot-through overlap, out-of-order edges and loss of switching. It sits alongside the open-loop top, either on the gate outputs or on looped-back pins, for on-chip self-test and for closing the loop later.

## Interface
- No parameters. Widths are fixed to match `dpwm`:
  - on-time: 11 bits
  - dead-time: 5 bits
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `enable`  in  1  capture enable
- `i_clr`  in  1  synchronous clear of the sticky flags
- `i_c1`  in  1  gate signal c1, synchronous to `clk`
- `i_c2`  in  1  gate signal c2, synchronous to `clk`
- `o_ton1`  out  11  c1 high cycles in the last complete period
- `o_dt1`  out  5  cycles with both gates low, c1 fall → c2 rise
- `o_ton2`  out  11  c2 high cycles
- `o_dt2`  out  5  cycles with both gates low, c2 fall → c1 rise
- `o_period`  out  13  total cycles from c1 rise to the next c1 rise
- `o_valid`  out  1  one-cycle pulse when all measurement outputs update
- `o_overlap`  out  1  sticky: c1 and c2 sampled high together
- `o_seq_err`  out  1  sticky: an edge arrived out of order
- `o_timeout`  out  1  sticky: no c1 rise within 8191 cycles

## Operation
- Input stage:
  - `s1`/`s2` register `i_c1`/`i_c2`; `p1`/`p2` hold the previous samples.
  - Rise is `s & ~p`; fall is `~s & p`.
- States: IDLE, ON1, DT1, ON2, DT2.
- Transitions:
  - IDLE → ON1 on c1 rise.
  - ON1 → DT1 on c1 fall.
  - DT1 → ON2 on c2 rise.
  - ON2 → DT2 on c2 fall.
  - DT2 → ON1 on c1 rise: publish all measurements and pulse `o_valid`.
- Phase counters:
  - The counter for the entered phase loads 1 on the transition cycle.
  - It increments on each further cycle in that phase.
  - Each phase count equals the number of samples spent in that phase.
- Period counter:
  - Loads 1 on entry to ON1 from IDLE or DT2.
  - Increments every cycle outside IDLE.
  - At publish, `o_period` = ton1 + dt1 + ton2 + dt2, each term taken before saturation.
- Saturation: each counter holds at its maximum (2047 / 31 / 8191); no wrap.
- Overlap: if `s1 & s2` in any non-IDLE state, set `o_overlap` and go to IDLE. The partial period is discarded.
- Sequence error:
  - c1 rise in DT1 sets `o_seq_err` and restarts ON1 (period counter loads 1) without a `o_valid` pulse.
  - c2 rise in ON1 or DT2 sets `o_seq_err` and goes to IDLE.
- Timeout: if the period counter reaches 8191 outside IDLE, set `o_timeout` and go to IDLE.
- Overlap takes priority over sequence error, which takes priority over normal transitions in the same cycle.
- `enable` low:
  - Forces IDLE and clears the counters.
  - Suppresses `o_valid`.
  - Measurement outputs and sticky flags hold.
- On `enable` rising, capture restarts from IDLE. The first `o_valid` needs two c1 rises.
- `i_clr`: clears all three sticky flags. If a flag-setting event occurs in the same cycle, the set wins.
- Reset: all outputs 0, state IDLE, `s*`/`p*` 0. Reset mid-period discards the period.

## Timing
- Input register adds 1 cycle. A level present on `i_c1` at clock edge k is seen as a rise at edge k+1.
- Publish latency:
  - `o_valid` and the new values are visible after edge k+1, where edge k samples the c1 rise ending the period.
  - Total latency is 2 clocks from pin.
- Measurement outputs change only with `o_valid`. They are stable between pulses.
- Flags assert 2 clocks after the offending pin condition.
- Minimum phase length is 1 cycle. A 1-cycle phase measures as 1.
- A 0-cycle dead-time (c1 fall and c2 rise sampled in the same cycle) is a sequence error. It is not recorded as dt = 0.

## Test plan
- `dpwm`-like stimulus c1 = 10 high, 3 low, c2 = 20 high, 4 low, repeated → after the second c1 rise, `o_valid` pulses with ton1=10, dt1=3, ton2=20, dt2=4, period=37. The pulse repeats every 37 cycles and no flags are set.
- Same pattern with dt1 = 40 cycles → dt1=31 (saturated), period=74.
- Force c2 high for 2 cycles during c1 high → `o_overlap`=1 2 clocks later. No `o_valid` for that period. After `i_clr`, the flag is 0 and capture resumes.
- c1 pulses twice with no c2 between them → `o_seq_err`=1, no `o_valid`. The next clean period publishes correct values.
- Hold c1 high indefinitely → `o_timeout`=1 8191 cycles after the state leaves IDLE. The state returns to IDLE and `o_valid` stays 0.
- Assert `rst` mid-ON2, then release and run the clean pattern → all outputs 0 during reset. The first `o_valid` comes at the second c1 rise after release, with values 10/3/20/4/37.

Source files
------------

// File: rtl/gate_capture.sv
// gate_capture: measures the on-times, dead-times and period of the two
// complementary gate drives c1/c2 in clk cycles. It also raises sticky
// flags for shoot-through overlap, out-of-order edges and loss of switching.
module gate_capture (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        i_clr,
  input  logic        i_c1,
  input  logic        i_c2,
  output logic [10:0] o_ton1,
  output logic [4:0]  o_dt1,
  output logic [10:0] o_ton2,
  output logic [4:0]  o_dt2,
  output logic [12:0] o_period,
  output logic        o_valid,
  output logic        o_overlap,
  output logic        o_seq_err,
  output logic        o_timeout
);

  localparam logic [10:0] TON_MAX    = 11'h7FF;
  localparam logic [4:0]  DT_MAX     = 5'h1F;
  localparam logic [12:0] PERIOD_MAX = 13'h1FFF;

  typedef enum logic [2:0] {IDLE, ON1, DT1, ON2, DT2} state_t;

  state_t state;
  state_t state_next;

  logic s1, s2, p1, p2;
  logic rise1, fall1, rise2, fall2;
  logic active;

  logic [10:0] ton1_cnt;
  logic [4:0]  dt1_cnt;
  logic [10:0] ton2_cnt;
  logic [4:0]  dt2_cnt;
  logic [12:0] period_cnt;

  logic overlap_hit;
  logic seq_hit;
  logic timeout_hit;

  logic publish;
  logic enter_on1, enter_dt1, enter_on2, enter_dt2;
  logic stay_on1, stay_dt1, stay_on2, stay_dt2;
  logic period_run;

  // Register the gate pins and keep the previous sample for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      p1 <= 1'b0;
      p2 <= 1'b0;
    end else begin
      s1 <= i_c1;
      s2 <= i_c2;
      p1 <= s1;
      p2 <= s2;
    end
  end

  assign rise1  = s1 & ~p1;
  assign fall1  = ~s1 & p1;
  assign rise2  = s2 & ~p2;
  assign fall2  = ~s2 & p2;
  assign active = (state != IDLE);

  // Fault conditions, already ranked: overlap, then sequence, then timeout.
  assign overlap_hit = enable & active & s1 & s2;
  assign seq_hit     = enable & active & ~overlap_hit &
                       (((state == DT1) & rise1) |
                        (((state == ON1) | (state == DT2)) & rise2));
  assign timeout_hit = enable & active & ~overlap_hit & ~seq_hit &
                       (period_cnt == PERIOD_MAX);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; faults override the normal edge sequence.
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else if (overlap_hit) begin
      state_next = IDLE;
    end else if (seq_hit) begin
      state_next = (state == DT1) ? ON1 : IDLE;
    end else if (timeout_hit) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (rise1) state_next = ON1;
        ON1:     if (fall1) state_next = DT1;
        DT1:     if (rise2) state_next = ON2;
        ON2:     if (fall2) state_next = DT2;
        DT2:     if (rise1) state_next = ON1;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode: publish strobe and per-phase load/increment controls.
  always_comb begin
    publish    = enable & (state == DT2) & (state_next == ON1) &
                 ~overlap_hit & ~seq_hit & ~timeout_hit;
    enter_on1  = (state_next == ON1) & (state != ON1);
    enter_dt1  = (state_next == DT1) & (state != DT1);
    enter_on2  = (state_next == ON2) & (state != ON2);
    enter_dt2  = (state_next == DT2) & (state != DT2);
    stay_on1   = (state_next == ON1) & (state == ON1);
    stay_dt1   = (state_next == DT1) & (state == DT1);
    stay_on2   = (state_next == ON2) & (state == ON2);
    stay_dt2   = (state_next == DT2) & (state == DT2);
    period_run = active & (state_next != IDLE);
  end

  // Saturating phase and period counters; cleared whenever capture is off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ton1_cnt   <= '0;
      dt1_cnt    <= '0;
      ton2_cnt   <= '0;
      dt2_cnt    <= '0;
      period_cnt <= '0;
    end else if (!enable) begin
      ton1_cnt   <= '0;
      dt1_cnt    <= '0;
      ton2_cnt   <= '0;
      dt2_cnt    <= '0;
      period_cnt <= '0;
    end else begin
      if (enter_on1)
        ton1_cnt <= 11'd1;
      else if (stay_on1 && ton1_cnt != TON_MAX)
        ton1_cnt <= ton1_cnt + 11'd1;

      if (enter_dt1)
        dt1_cnt <= 5'd1;
      else if (stay_dt1 && dt1_cnt != DT_MAX)
        dt1_cnt <= dt1_cnt + 5'd1;

      if (enter_on2)
        ton2_cnt <= 11'd1;
      else if (stay_on2 && ton2_cnt != TON_MAX)
        ton2_cnt <= ton2_cnt + 11'd1;

      if (enter_dt2)
        dt2_cnt <= 5'd1;
      else if (stay_dt2 && dt2_cnt != DT_MAX)
        dt2_cnt <= dt2_cnt + 5'd1;

      if (enter_on1)
        period_cnt <= 13'd1;
      else if (period_run && period_cnt != PERIOD_MAX)
        period_cnt <= period_cnt + 13'd1;
      else if (state_next == IDLE)
        period_cnt <= '0;
    end
  end

  // Publish a completed period; the period counter holds the unsaturated total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ton1   <= '0;
      o_dt1    <= '0;
      o_ton2   <= '0;
      o_dt2    <= '0;
      o_period <= '0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= publish;
      if (publish) begin
        o_ton1   <= ton1_cnt;
        o_dt1    <= dt1_cnt;
        o_ton2   <= ton2_cnt;
        o_dt2    <= dt2_cnt;
        o_period <= period_cnt;
      end
    end
  end

  // Sticky fault flags; a same-cycle set beats the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_overlap <= 1'b0;
      o_seq_err <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_overlap <= overlap_hit | (o_overlap & ~i_clr);
      o_seq_err <= seq_hit     | (o_seq_err & ~i_clr);
      o_timeout <= timeout_hit | (o_timeout & ~i_clr);
    end
  end

endmodule

// File: tb/tb_gate_capture.sv
// Directed bench for gate_capture: drives c1/c2 gate patterns and compares
// the published measurements and sticky flags against hand-computed values.
module tb_gate_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        i_clr;
  logic        i_c1;
  logic        i_c2;
  logic [10:0] o_ton1;
  logic [4:0]  o_dt1;
  logic [10:0] o_ton2;
  logic [4:0]  o_dt2;
  logic [12:0] o_period;
  logic        o_valid;
  logic        o_overlap;
  logic        o_seq_err;
  logic        o_timeout;

  int assertion_count = 0;
  int fail_count      = 0;

  int cycle_no         = 0;
  int valid_count      = 0;
  int valid_delta      = 0;
  int prev_valid_cycle = 0;
  int base;

  gate_capture dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .i_clr     (i_clr),
    .i_c1      (i_c1),
    .i_c2      (i_c2),
    .o_ton1    (o_ton1),
    .o_dt1     (o_dt1),
    .o_ton2    (o_ton2),
    .o_dt2     (o_dt2),
    .o_period  (o_period),
    .o_valid   (o_valid),
    .o_overlap (o_overlap),
    .o_seq_err (o_seq_err),
    .o_timeout (o_timeout)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Cycle stamp used to measure the spacing of valid pulses.
  always @(posedge clk) begin
    cycle_no <= cycle_no + 1;
  end

  // Count valid pulses away from the active edge and remember their spacing.
  always @(negedge clk) begin
    if (o_valid) begin
      valid_count      <= valid_count + 1;
      valid_delta      <= cycle_no - prev_valid_cycle;
      prev_valid_cycle <= cycle_no;
    end
  end

  // Hard stop if the bench ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int got, input int expected);
    assertion_count++;
    if (got !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, expected);
    end
  endtask

  // Hold the gate levels for n sampling edges, then settle 1 ns past the edge.
  task automatic drive(input logic c1, input logic c2, input int n);
    i_c1 = c1;
    i_c2 = c2;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One dpwm-like period: c1 on, dead-time, c2 on, dead-time.
  task automatic applyStimulus(input int t1, input int d1, input int t2, input int d2);
    drive(1'b1, 1'b0, t1);
    drive(1'b0, 1'b0, d1);
    drive(1'b0, 1'b1, t2);
    drive(1'b0, 1'b0, d2);
  endtask

  // Drop enable briefly so the next test starts from IDLE with gates low.
  task automatic restartCapture();
    enable = 1'b0;
    drive(1'b0, 1'b0, 2);
    enable = 1'b1;
  endtask

  task automatic clearFlags();
    i_clr = 1'b1;
    drive(1'b0, 1'b0, 1);
    i_clr = 1'b0;
  endtask

  task automatic checkMeasure(input string tag, input int t1, input int d1,
                              input int t2, input int d2, input int p);
    checkOutput({tag, "_ton1"},   o_ton1,   t1);
    checkOutput({tag, "_dt1"},    o_dt1,    d1);
    checkOutput({tag, "_ton2"},   o_ton2,   t2);
    checkOutput({tag, "_dt2"},    o_dt2,    d2);
    checkOutput({tag, "_period"}, o_period, p);
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    i_clr  = 1'b0;
    i_c1   = 1'b0;
    i_c2   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkMeasure("rst", 0, 0, 0, 0, 0);
    checkOutput("rst_valid",   o_valid,   0);
    checkOutput("rst_overlap", o_overlap, 0);
    checkOutput("rst_seq",     o_seq_err, 0);
    checkOutput("rst_timeout", o_timeout, 0);

    rst    = 1'b0;
    enable = 1'b1;
    drive(1'b0, 1'b0, 3);

    $display("[TB] clean 10/3/20/4 pattern");
    base = valid_count;
    repeat (3) applyStimulus(10, 3, 20, 4);
    drive(1'b1, 1'b0, 3);
    checkOutput("A_valid_cnt", valid_count - base, 3);
    checkMeasure("A", 10, 3, 20, 4, 37);
    checkOutput("A_interval", valid_delta, 37);
    checkOutput("A_overlap",  o_overlap, 0);
    checkOutput("A_seq",      o_seq_err, 0);
    checkOutput("A_timeout",  o_timeout, 0);

    $display("[TB] dead-time saturation");
    restartCapture();
    checkOutput("B_hold_ton2", o_ton2, 20);
    base = valid_count;
    repeat (2) applyStimulus(10, 40, 20, 4);
    drive(1'b1, 1'b0, 3);
    checkOutput("B_valid_cnt", valid_count - base, 2);
    checkMeasure("B", 10, 31, 20, 4, 74);

    $display("[TB] overlap");
    restartCapture();
    base = valid_count;
    applyStimulus(10, 3, 20, 4);
    drive(1'b1, 1'b0, 4);
    drive(1'b1, 1'b1, 2);
    checkOutput("C_overlap_set", o_overlap, 1);
    checkOutput("C_seq_clear",   o_seq_err, 0);
    drive(1'b1, 1'b0, 4);
    drive(1'b0, 1'b0, 5);
    checkOutput("C_valid_cnt", valid_count - base, 1);
    checkMeasure("C_hold", 10, 3, 20, 4, 37);
    clearFlags();
    checkOutput("C_overlap_clr", o_overlap, 0);
    base = valid_count;
    repeat (2) applyStimulus(5, 2, 7, 3);
    drive(1'b1, 1'b0, 3);
    checkOutput("C_resume_cnt", valid_count - base, 2);
    checkMeasure("C_resume", 5, 2, 7, 3, 17);
    checkOutput("C_overlap_after", o_overlap, 0);

    $display("[TB] c1 pulses twice without c2");
    restartCapture();
    base = valid_count;
    drive(1'b1, 1'b0, 6);
    drive(1'b0, 1'b0, 3);
    drive(1'b1, 1'b0, 6);
    checkOutput("D_seq_set",  o_seq_err, 1);
    checkOutput("D_valid_none", valid_count - base, 0);
    drive(1'b0, 1'b0, 3);
    drive(1'b0, 1'b1, 8);
    drive(1'b0, 1'b0, 2);
    drive(1'b1, 1'b0, 3);
    checkOutput("D_valid_cnt", valid_count - base, 1);
    checkMeasure("D", 6, 3, 8, 2, 19);
    clearFlags();
    checkOutput("D_seq_clr", o_seq_err, 0);

    $display("[TB] one-cycle phases");
    restartCapture();
    base = valid_count;
    repeat (2) applyStimulus(1, 1, 1, 1);
    drive(1'b1, 1'b0, 3);
    checkOutput("E_valid_cnt", valid_count - base, 2);
    checkMeasure("E", 1, 1, 1, 1, 4);
    checkOutput("E_flags", {o_overlap, o_seq_err, o_timeout}, 0);

    $display("[TB] zero dead-time");
    restartCapture();
    base = valid_count;
    drive(1'b1, 1'b0, 5);
    drive(1'b0, 1'b1, 5);
    drive(1'b0, 1'b0, 3);
    checkOutput("F_seq_set",    o_seq_err, 1);
    checkOutput("F_overlap",    o_overlap, 0);
    checkOutput("F_valid_none", valid_count - base, 0);
    clearFlags();

    $display("[TB] timeout with c1 stuck high");
    restartCapture();
    base = valid_count;
    drive(1'b1, 1'b0, 8192);
    checkOutput("G_timeout_early", o_timeout, 0);
    drive(1'b1, 1'b0, 1);
    checkOutput("G_timeout_set", o_timeout, 1);
    checkOutput("G_valid_none",  valid_count - base, 0);
    checkOutput("G_other_flags", {o_overlap, o_seq_err}, 0);

    $display("[TB] reset mid-ON2");
    restartCapture();
    checkOutput("H_timeout_hold", o_timeout, 1);
    applyStimulus(10, 3, 20, 4);
    drive(1'b1, 1'b0, 10);
    drive(1'b0, 1'b0, 3);
    drive(1'b0, 1'b1, 5);
    rst = 1'b1;
    drive(1'b0, 1'b0, 3);
    checkMeasure("H_rst", 0, 0, 0, 0, 0);
    checkOutput("H_rst_valid", o_valid, 0);
    checkOutput("H_rst_flags", {o_overlap, o_seq_err, o_timeout}, 0);
    rst  = 1'b0;
    base = valid_count;
    applyStimulus(10, 3, 20, 4);
    checkOutput("H_first_rise_none", valid_count - base, 0);
    drive(1'b1, 1'b0, 3);
    checkOutput("H_valid_cnt", valid_count - base, 1);
    checkMeasure("H", 10, 3, 20, 4, 37);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertion_count, fail_count);
    $finish;
  end

endmodule
